// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding (value = one-hot bit index), the
// next-state function, the IR capture pattern and the all-ones BYPASS opcode.
package jtag_tap_pkg;

  localparam int IDX_TLR      = 0;
  localparam int IDX_RTI      = 1;
  localparam int IDX_SEL_DR   = 2;
  localparam int IDX_CAP_DR   = 3;
  localparam int IDX_SHIFT_DR = 4;
  localparam int IDX_EXIT1_DR = 5;
  localparam int IDX_PAUSE_DR = 6;
  localparam int IDX_EXIT2_DR = 7;
  localparam int IDX_UPD_DR   = 8;
  localparam int IDX_SEL_IR   = 9;
  localparam int IDX_CAP_IR   = 10;
  localparam int IDX_SHIFT_IR = 11;
  localparam int IDX_EXIT1_IR = 12;
  localparam int IDX_PAUSE_IR = 13;
  localparam int IDX_EXIT2_IR = 14;
  localparam int IDX_UPD_IR   = 15;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'(IDX_TLR),
    TAP_RTI      = 4'(IDX_RTI),
    TAP_SEL_DR   = 4'(IDX_SEL_DR),
    TAP_CAP_DR   = 4'(IDX_CAP_DR),
    TAP_SHIFT_DR = 4'(IDX_SHIFT_DR),
    TAP_EXIT1_DR = 4'(IDX_EXIT1_DR),
    TAP_PAUSE_DR = 4'(IDX_PAUSE_DR),
    TAP_EXIT2_DR = 4'(IDX_EXIT2_DR),
    TAP_UPD_DR   = 4'(IDX_UPD_DR),
    TAP_SEL_IR   = 4'(IDX_SEL_IR),
    TAP_CAP_IR   = 4'(IDX_CAP_IR),
    TAP_SHIFT_IR = 4'(IDX_SHIFT_IR),
    TAP_EXIT1_IR = 4'(IDX_EXIT1_IR),
    TAP_PAUSE_IR = 4'(IDX_PAUSE_IR),
    TAP_EXIT2_IR = 4'(IDX_EXIT2_IR),
    TAP_UPD_IR   = 4'(IDX_UPD_IR)
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic logic [7:0] BYPASS_OPCODE_ALL1(input int ir_width);
    return 8'((1 << ir_width) - 1);
  endfunction

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: tms-driven transitions with a registered
// one-hot view; the encoded state and its successor are exported as well.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic        tck,
  input  logic        trst_n,
  input  logic        tms,
  output tap_state_e  state,
  output tap_state_e  state_next,
  output logic [15:0] state_onehot
);

  assign state_next = tap_next(state, tms);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state        <= TAP_TLR;
      state_onehot <= 16'h0001;
    end else begin
      state        <= state_next;
      state_onehot <= 16'(1) << state_next;
    end
  end

endmodule

// File: rtl/jtag_tap_mudr.sv
// JTAG TAP with BYPASS, IDCODE and NUM_UDR user data registers.
// Define JTAG_TAP_UPD_PULSE_EN to get a registered per-UDR update strobe.
module jtag_tap_mudr
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH         = 4,
  parameter int          NUM_UDR          = 2,
  parameter int          UDR_WIDTH        = 16,
  parameter int          IDCODE_OPCODE    = 1,
  parameter int          USER_OPCODE_BASE = 2,
  parameter logic [3:0]  VERSION          = 4'h0,
  parameter logic [15:0] PART             = 16'h0000,
  parameter logic [10:0] MANUF            = 11'h000
) (
  input  logic                           tck,
  input  logic                           trst_n,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  output logic                           tdo_en,
  output logic [15:0]                    tap_state,
  output logic [IR_WIDTH-1:0]            instructions,
  input  logic [NUM_UDR*UDR_WIDTH-1:0]   udr_capture,
  output logic [NUM_UDR*UDR_WIDTH-1:0]   udr_q,
  output logic [NUM_UDR-1:0]             udr_upd_pulse
);

  localparam logic [IR_WIDTH-1:0] IR_ALL1      = IR_WIDTH'(BYPASS_OPCODE_ALL1(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_CAP_VALUE = IR_WIDTH'(IR_CAPTURE);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE    = IR_WIDTH'(IDCODE_OPCODE);
  localparam logic [31:0]         IDCODE_VALUE = {VERSION, PART, MANUF, 1'b1};

  tap_state_e state;
  tap_state_e state_next;

  logic [IR_WIDTH-1:0]  ir_sr;
  logic [31:0]          idcode_sr;
  logic                 bypass_sr;
  logic [UDR_WIDTH-1:0] udr_sr [NUM_UDR];

  logic                 sel_idcode;
  logic                 sel_bypass;
  logic [NUM_UDR-1:0]   udr_sel;
  logic                 dr_lsb;

  jtag_tap_fsm u_fsm (
    .tck          (tck),
    .trst_n       (trst_n),
    .tms          (tms),
    .state        (state),
    .state_next   (state_next),
    .state_onehot (tap_state)
  );

  // IDCODE wins over everything; all-ones is reserved for BYPASS even if a
  // user opcode lands there. User opcodes are distinct, so at most one matches.
  always_comb begin
    sel_idcode = (instructions == IR_IDCODE);
    udr_sel    = '0;
    if (!sel_idcode && (instructions != IR_ALL1)) begin
      for (int i = 0; i < NUM_UDR; i++) begin
        udr_sel[i] = (int'(instructions) == USER_OPCODE_BASE + i);
      end
    end
    sel_bypass = !sel_idcode && (udr_sel == '0);
  end

  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_idcode) dr_lsb = idcode_sr[0];
    for (int i = 0; i < NUM_UDR; i++) begin
      if (udr_sel[i]) dr_lsb = udr_sr[i][0];
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_sr        <= '0;
      instructions <= IR_IDCODE;
      idcode_sr    <= '0;
      bypass_sr    <= 1'b0;
      udr_sr       <= '{default: '0};
      udr_q        <= '0;
    end else begin
      case (state)
        TAP_CAP_IR:   ir_sr <= IR_CAP_VALUE;
        TAP_SHIFT_IR: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        TAP_UPD_IR:   instructions <= ir_sr;
        TAP_CAP_DR: begin
          if (sel_idcode) idcode_sr <= IDCODE_VALUE;
          if (sel_bypass) bypass_sr <= 1'b0;
          for (int i = 0; i < NUM_UDR; i++) begin
            if (udr_sel[i]) udr_sr[i] <= udr_capture[i*UDR_WIDTH +: UDR_WIDTH];
          end
        end
        TAP_SHIFT_DR: begin
          if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
          if (sel_bypass) bypass_sr <= tdi;
          // Shift form that stays legal for UDR_WIDTH == 1.
          for (int i = 0; i < NUM_UDR; i++) begin
            if (udr_sel[i])
              udr_sr[i] <= (udr_sr[i] >> 1) | (UDR_WIDTH'(tdi) << (UDR_WIDTH-1));
          end
        end
        TAP_UPD_DR: begin
          for (int i = 0; i < NUM_UDR; i++) begin
            if (udr_sel[i]) udr_q[i*UDR_WIDTH +: UDR_WIDTH] <= udr_sr[i];
          end
        end
        default: ;
      endcase
      // Applied on entry so the values already hold for the first TLR cycle.
      if (state_next == TAP_TLR) begin
        instructions <= IR_IDCODE;
        udr_q        <= '0;
      end
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);
      if (state == TAP_SHIFT_IR)      tdo <= ir_sr[0];
      else if (state == TAP_SHIFT_DR) tdo <= dr_lsb;
      else                            tdo <= 1'b0;
    end
  end

`ifdef JTAG_TAP_UPD_PULSE_EN
  // Instructions cannot change on the DR path, so udr_sel is valid on entry.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) udr_upd_pulse <= '0;
    else         udr_upd_pulse <= (state_next == TAP_UPD_DR) ? udr_sel : '0;
  end
`else
  assign udr_upd_pulse = '0;
`endif

endmodule

// File: tb/tb_jtag_tap_mudr.sv
// Directed bench for jtag_tap_mudr with a transaction-level TAP model checked
// every cycle, plus literal expectations for each scan.
module tb_jtag_tap_mudr;

  localparam int          IRW     = 4;
  localparam int          NU      = 2;
  localparam int          UW      = 16;
  localparam int          IDC_OP  = 1;
  localparam int          BASE    = 2;
  localparam logic [3:0]  VER     = 4'h1;
  localparam logic [15:0] PARTNO  = 16'h5A3C;
  localparam logic [10:0] MFR     = 11'h02A;
`ifdef JTAG_TAP_UPD_PULSE_EN
  localparam bit PULSE_ON = 1'b1;
`else
  localparam bit PULSE_ON = 1'b0;
`endif

  logic              tck = 1'b0;
  logic              trst_n;
  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              tdo_en;
  logic [15:0]       tap_state;
  logic [IRW-1:0]    instructions;
  logic [NU*UW-1:0]  udr_capture;
  logic [NU*UW-1:0]  udr_q;
  logic [NU-1:0]     udr_upd_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic          last_tdo;
  logic [NU-1:0] last_pulse;

  // Model state: the TAP position is an index into the standard transition table.
  int             m_state;
  logic [IRW-1:0] m_ir, m_ir_sr;
  logic [31:0]    m_idc;
  logic           m_byp;
  logic [UW-1:0]  m_udr_sr [NU];
  logic [UW-1:0]  m_udr_q  [NU];

  // nxt[s] = '{next when tms=0, next when tms=1}
  int nxt [16][2] = '{
    '{1, 0},  '{1, 2},  '{3, 9},   '{4, 5},   '{4, 5},   '{6, 8},   '{6, 7},   '{4, 8},
    '{1, 2},  '{10, 0}, '{11, 12}, '{11, 12}, '{13, 15}, '{13, 14}, '{11, 15}, '{1, 2}
  };

  jtag_tap_mudr #(
    .IR_WIDTH         (IRW),
    .NUM_UDR          (NU),
    .UDR_WIDTH        (UW),
    .IDCODE_OPCODE    (IDC_OP),
    .USER_OPCODE_BASE (BASE),
    .VERSION          (VER),
    .PART             (PARTNO),
    .MANUF            (MFR)
  ) dut (
    .tck           (tck),
    .trst_n        (trst_n),
    .tms           (tms),
    .tdi           (tdi),
    .tdo           (tdo),
    .tdo_en        (tdo_en),
    .tap_state     (tap_state),
    .instructions  (instructions),
    .udr_capture   (udr_capture),
    .udr_q         (udr_q),
    .udr_upd_pulse (udr_upd_pulse)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 = IDCODE, -2 = BYPASS, otherwise the UDR index
  function automatic int sel_of(input logic [IRW-1:0] op);
    if (int'(op) == IDC_OP) return -1;
    if (op == {IRW{1'b1}}) return -2;
    for (int i = 0; i < NU; i++) if (int'(op) == BASE + i) return i;
    return -2;
  endfunction

  function automatic logic dr_lsb(input int sel);
    if (sel == -1) return m_idc[0];
    if (sel == -2) return m_byp;
    return m_udr_sr[sel][0];
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_ir     = IRW'(IDC_OP);
    m_ir_sr  = '0;
    m_idc    = '0;
    m_byp    = 1'b0;
    m_udr_sr = '{default: '0};
    m_udr_q  = '{default: '0};
  endtask

  task automatic model_step();
    int sel;
    if (!trst_n) return;
    sel = sel_of(m_ir);
    case (m_state)
      3: begin
        if (sel == -1)      m_idc = {VER, PARTNO, MFR, 1'b1};
        else if (sel == -2) m_byp = 1'b0;
        else                m_udr_sr[sel] = udr_capture[sel*UW +: UW];
      end
      4: begin
        if (sel == -1)      m_idc = {tdi, m_idc[31:1]};
        else if (sel == -2) m_byp = tdi;
        else                m_udr_sr[sel] = {tdi, m_udr_sr[sel][UW-1:1]};
      end
      8:  if (sel >= 0) m_udr_q[sel] = m_udr_sr[sel];
      10: m_ir_sr = IRW'(1);
      11: m_ir_sr = {tdi, m_ir_sr[IRW-1:1]};
      15: m_ir = m_ir_sr;
      default: ;
    endcase
    m_state = nxt[m_state][tms];
    if (m_state == 0) begin
      m_ir    = IRW'(IDC_OP);
      m_udr_q = '{default: '0};
    end
  endtask

  task automatic check_cycle();
    int              sel;
    logic [15:0]     e_st;
    logic            e_en, e_tdo;
    logic [NU*UW-1:0] e_q;
    logic [NU-1:0]   e_p;
    sel   = sel_of(m_ir);
    e_st  = 16'(1) << m_state;
    e_en  = (m_state == 4) || (m_state == 11);
    e_tdo = 1'b0;
    if (m_state == 11)     e_tdo = m_ir_sr[0];
    else if (m_state == 4) e_tdo = dr_lsb(sel);
    for (int i = 0; i < NU; i++) e_q[i*UW +: UW] = m_udr_q[i];
    e_p = '0;
    if (PULSE_ON && m_state == 8 && sel >= 0) e_p[sel] = 1'b1;
    chk("tap_state", tap_state, e_st);
    chk("instructions", instructions, e_ir_of());
    chk("tdo_en", tdo_en, e_en);
    chk("tdo", tdo, e_tdo);
    chk("udr_q", udr_q, e_q);
    chk("udr_upd_pulse", udr_upd_pulse, e_p);
    last_tdo   = tdo;
    last_pulse = udr_upd_pulse;
  endtask

  function automatic logic [IRW-1:0] e_ir_of();
    return m_ir;
  endfunction

  task automatic cyc(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(negedge tck);
    #1;
    check_cycle();
    @(posedge tck);
    model_step();
    #2;
  endtask

  task automatic scan_ir(input logic [IRW-1:0] din, output logic [IRW-1:0] dout);
    dout = '0;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    for (int k = 0; k < IRW; k++) begin
      cyc(k == IRW-1, din[k]);
      dout[k] = last_tdo;
    end
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input logic [63:0] din, input int len, input int pause_at,
                         output logic [63:0] dout);
    dout = '0;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    for (int k = 0; k < len; k++) begin
      cyc((k == len-1) || (k == pause_at), din[k]);
      dout[k] = last_tdo;
      if (k == pause_at && k != len-1) begin
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
      end
    end
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
  endtask

  initial begin
    logic [IRW-1:0] ir_out;
    logic [63:0]    dr_out;
    trst_n      = 1'b0;
    tms         = 1'b1;
    tdi         = 1'b0;
    udr_capture = {16'h1234, 16'hCAFE};
    model_reset();
    @(posedge tck);
    #2;

    // Reset state
    repeat (3) cyc(1'b1, 1'b0);
    chk("reset_tap_state", tap_state, 16'h0001);
    chk("reset_instructions", instructions, 4'h1);
    chk("reset_udr_q", udr_q, 32'h0);
    trst_n = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // IDCODE read straight after reset
    scan_dr(64'h0, 32, -1, dr_out);
    chk("idcode_stream", dr_out[31:0], 32'h15A3C055);

    // All-ones BYPASS: one-bit delay
    scan_ir(4'hF, ir_out);
    chk("ir_capture_01", ir_out, 4'h1);
    scan_dr(64'hA5, 8, -1, dr_out);
    chk("bypass_a5", dr_out[7:0], 8'h4A);

    // UDR1 capture/update with a pause in the middle
    scan_ir(4'h3, ir_out);
    chk("ir_capture_udr1", ir_out, 4'h1);
    scan_dr(64'hBEEF, 16, 7, dr_out);
    chk("udr1_capture", dr_out[15:0], 16'h1234);
    chk("udr1_update", udr_q, 32'hBEEF_0000);
    chk("udr1_pulse", last_pulse, PULSE_ON ? 2'b10 : 2'b00);

    // Unused opcode acts as BYPASS and leaves udr_q alone
    scan_ir(4'hE, ir_out);
    chk("udr_q_hold_ir", udr_q, 32'hBEEF_0000);
    scan_dr(64'h3C, 8, -1, dr_out);
    chk("unused_op_bypass", dr_out[7:0], 8'h78);

    // Reset in the middle of a UDR0 scan
    scan_ir(4'h2, ir_out);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b1);
    trst_n = 1'b0;
    model_reset();
    #1;
    chk("midscan_tap_state", tap_state, 16'h0001);
    chk("midscan_udr_q", udr_q, 32'h0);
    chk("midscan_pulse", udr_upd_pulse, 2'b00);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    trst_n = 1'b1;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);

    // UDR0 load, then five tms=1 from Shift-DR back to TLR
    scan_ir(4'h2, ir_out);
    scan_dr(64'h55AA, 16, -1, dr_out);
    chk("udr0_capture", dr_out[15:0], 16'hCAFE);
    chk("udr0_update", udr_q, 32'h0000_55AA);
    scan_ir(4'hF, ir_out);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    chk("tms5_tap_state", tap_state, 16'h0001);
    chk("tms5_instructions", instructions, 4'h1);
    chk("tms5_udr_q", udr_q, 32'h0);
    repeat (2) cyc(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_mudr.md
Name: jtag_tap_mudr

Overview:
- Parametrised IEEE 1149.1 TAP controller.
- Supports configurable IR width and built-in BYPASS and IDCODE registers.
- Adds NUM_UDR internal user data registers, each with a parallel capture input and a parallel update output.
- Sits at the chip JTAG pins and feeds debug/config logic.

Parameters:
- IR_WIDTH, 4: instruction register width, 2..8.
- NUM_UDR, 2: number of user data registers, 1..8.
- UDR_WIDTH, 16: bits per user data register, 1..64.
- IDCODE_OPCODE, 1: opcode selecting IDCODE.
- USER_OPCODE_BASE, 2: UDR i is selected by opcode USER_OPCODE_BASE+i.
- VERSION, 0: 4-bit IDCODE version field.
- PART, 0: 16-bit IDCODE part number field.
- MANUF, 0: 11-bit IDCODE manufacturer field.

Ports:
- tck input 1: test clock (the only clock).
- trst_n input 1: asynchronous active-low reset.
- tms input 1: mode select, sampled on tck rise.
- tdi input 1: serial data in, sampled on tck rise.
- tdo output 1: serial data out.
- tdo_en output 1: output enable for tdo.
- tap_state output 16: one-hot FSM state.
- instructions output IR_WIDTH: current (updated) IR.
- udr_capture input NUM_UDR*UDR_WIDTH: capture values; UDR i occupies bits [i*UDR_WIDTH +: UDR_WIDTH].
- udr_q output NUM_UDR*UDR_WIDTH: updated UDR contents, same packing as udr_capture.
- udr_upd_pulse output NUM_UDR: per-UDR update strobe (optional feature).

Behaviour:
- Clocking and reset:
  - Single clock tck.
  - trst_n low asynchronously forces: FSM=Test-Logic-Reset (TLR), instructions=IDCODE_OPCODE, udr_q=0, tdo=0, tdo_en=0, udr_upd_pulse=0.
- tap_state one-hot bit order:
  - 0 TLR, 1 Run-Test/Idle, 2 Sel-DR, 3 Cap-DR, 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Upd-DR.
  - 9 Sel-IR, 10 Cap-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Upd-IR.
  - Standard 1149.1 transitions on tck rise, driven by tms.
  - Five consecutive tms=1 reach TLR from any state.
- While in TLR (synchronous):
  - instructions=IDCODE_OPCODE.
  - udr_q=0.
- IR path:
  - Cap-IR loads the IR shift register with {0..0,2'b01}.
  - Shift-IR shifts LSB-first: tdi enters the MSB, the LSB drives tdo.
  - Upd-IR copies the shift register to instructions.
- DR selection by instructions:
  - IDCODE_OPCODE selects the 32-bit IDCODE register.
  - USER_OPCODE_BASE+i (i<NUM_UDR) selects UDR i.
  - All-ones, and every other opcode, select 1-bit BYPASS.
  - If opcodes overlap, IDCODE has priority, then the lowest i.
- Per-register DR behaviour:
  - IDCODE: Cap-DR loads {VERSION,PART,MANUF,1'b1}.
  - BYPASS: Cap-DR loads 0.
  - UDR i: Cap-DR loads its udr_capture slice; Upd-DR copies its shift register to its udr_q slice.
  - Shift-DR shifts LSB-first, same as the IR path.
- Holds:
  - Pause and Exit states hold all shift registers.
  - udr_q changes only in Upd-DR of the selected UDR, in TLR, or on trst_n.
- tdo timing:
  - tdo and tdo_en are registered on the tck falling edge.
  - tdo_en=1 only in Shift-DR/Shift-IR; tdo takes the selected register's LSB.
  - Otherwise tdo_en=0 and tdo=0.
  - Latency: a bit shifted in reaches tdo after its register length in tck cycles.
- Mid-scan events:
  - Reset mid-scan aborts the scan with no update; udr_q reads 0.
  - An instruction change does not alter udr_q.

Optional Feature:
- Macro: JTAG_TAP_UPD_PULSE_EN.
- Defined: udr_upd_pulse[i]=1 for exactly the tck cycle spent in Upd-DR while UDR i is selected; registered; 0 otherwise.
- Undefined: udr_upd_pulse is tied to 0 and no logic is generated for it.

Decomposition:
- Package jtag_tap_pkg holds:
  - the tap_state_e enum (16 states, index per the order above);
  - the one-hot index constants;
  - BYPASS_OPCODE_ALL1 as a function of IR_WIDTH;
  - the IR capture constant 2'b01.
- Sub-module jtag_tap_fsm: tms to next state, one-hot output. It is shared with future TAP variants.

Test Plan:
- trst_n pulse, then tms=1 x5 from Shift-DR -> tap_state=16'h0001, instructions=IDCODE_OPCODE.
- VERSION=1, PART=16'h5A3C, MANUF=11'h02A, reset then 32-bit DR scan -> tdo stream LSB-first = 32'h15A3C055; tdo_en high only during Shift-DR.
- IR scan of all-ones, then DR scan of 8 bits 8'hA5 -> tdo = 0 followed by A5 delayed by one bit.
- IR=USER_OPCODE_BASE+1, DR scan of 16'hBEEF with udr_capture slice1=16'h1234 -> tdo shows 16'h1234; after Upd-DR udr_q slice1=16'hBEEF, slice0=0.
  - With JTAG_TAP_UPD_PULSE_EN defined: udr_upd_pulse=2'b10 for one cycle.
- IR scan -> Cap-IR shifts out 2'b01 in the LSBs.
  - Unused opcode (e.g. 4'hE) behaves as BYPASS.
- trst_n asserted mid Shift-DR of UDR0 -> FSM=TLR immediately, udr_q=0, no Upd-DR pulse.
